pulse_burst_gen: RTL
====================

# pulse_burst_gen

Transmit-side counterpart of the team's pulse counters. On a start request, the block emits a burst of single-cycle pulses on `sigOut`, with a programmable count and inter-pulse gap. It then flags completion. It drives the `sigIn` input of a downstream pulse counter: a burst of length 10 produces exactly one terminal-count pulse at a counter configured for 10.

## Interface
Parameters:
- `CNT_W`, 4: width of `burstLen` and `gapLen` and of the internal counters.

Ports:
- `clk`  input  1  system clock; all logic on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `enable`  input  1  block enable; low aborts any burst.
- `start`  input  1  burst request, sampled only in IDLE.
- `burstLen`  input  CNT_W  number of pulses to emit (0..2^CNT_W-1).
- `gapLen`  input  CNT_W  low cycles between consecutive pulses (0..2^CNT_W-1).
- `sigOut`  output  1  pulse stream; each pulse is exactly one cycle high.
- `busy`  output  1  high while a burst is in progress, including the done cycle.
- `done`  output  1  one-cycle completion strobe.

## Operation
- All outputs are registered. Reset value: `sigOut`=0, `busy`=0, `done`=0, state=IDLE, counters=0.
- `rst` takes priority over all other inputs. `enable`=0 has the next-highest priority: it forces IDLE with all outputs 0 on the next edge, and no `done` is issued.
- States:
  - IDLE: outputs 0. If `start`=1 and `enable`=1, latch `burstLen`→len_r, `gapLen`→gap_r, clear sent count. If len_r would be 0, go to DONE; otherwise go to PULSE.
  - PULSE: `sigOut`=1 for one cycle and the sent count increments.
    - If sent+1 == len_r, go to DONE.
    - Else if gap_r==0, stay in PULSE (back-to-back pulses).
    - Else load the gap counter with gap_r and go to GAP.
  - GAP: `sigOut`=0. Decrement the gap counter. When it reaches 1 (after gap_r cycles in GAP), go to PULSE.
  - DONE: `done`=1 and `busy`=1 for one cycle, then go to IDLE.
- `busy`=1 in PULSE, GAP and DONE.
- `start` is ignored outside IDLE. Changes to `burstLen` and `gapLen` during a burst have no effect, because they are latched at start.
- A `start` held high through DONE does not retrigger in the DONE cycle. It is honoured on the first IDLE cycle, so the new burst begins one cycle after DONE.
- Counter arithmetic is CNT_W bits unsigned with no wrap. The sent count never exceeds len_r.

## Timing
- Cycle 0 is the cycle in which `start`=1 is sampled in IDLE.
- Let N = burstLen and G = gapLen, both latched at cycle 0. For N≥1:
  - Pulse k (k=0..N-1) is high in cycle 1+k·(G+1).
  - `done` is high in cycle 2+(N-1)·(G+1).
  - `busy` is high from cycle 1 through the `done` cycle inclusive.
  - Total occupancy is N·(G+1)−G+1 cycles.
- N=0: `done` and `busy` are high in cycle 1 only. No pulse is emitted.
- Earliest next start: it is sampled in the cycle after `done`, so its first pulse appears 2 cycles after `done`.
- Abort: if `enable` falls in cycle t, the block is in IDLE with all outputs 0 from cycle t+1. A pulse already high in cycle t completes normally.
- Reset mid-burst behaves the same as abort, and the counters are also cleared.

## Test plan
- Reset, then N=3, G=2, start at cycle 0 → `sigOut` high in cycles 1, 4, 7; `done` in cycle 8; `busy` high in cycles 1–8; all low from cycle 9.
- N=10, G=0 → ten consecutive high cycles 1–10 and `done` in cycle 11. When looped into a downstream counter configured for 10, the counter emits exactly one output pulse.
- N=0, G=5 → no pulse; `done` and `busy` high in cycle 1 only.
- N=4, G=1, drop `enable` in cycle 4 (a GAP cycle) → pulses in cycles 1 and 3 only, no `done`, all outputs 0 from cycle 5. A repeated `start` while busy is ignored.
- `start` held high continuously with N=2, G=0 → pulses in cycles 1–2, `done` in 3, IDLE in 4, pulses again in cycles 5–6. Assert `rst` in cycle 5 → all outputs 0 from cycle 6.

Source files
------------

// File: rtl/pulse_burst_gen.sv
// pulse_burst_gen: emits a burst of burstLen single-cycle pulses spaced by gapLen low cycles, then strobes done.
module pulse_burst_gen #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             start,
    input  logic [CNT_W-1:0] burstLen,
    input  logic [CNT_W-1:0] gapLen,
    output logic             sigOut,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, PULSE, GAP, DONE} state_t;
    localparam logic [CNT_W-1:0] ONE = 1;
    state_t state_q;
    logic [CNT_W-1:0] len_q, gap_q, sent_q, gcnt_q, sent_d;
    logic sig_q, busy_q, done_q;
    assign sent_d = sent_q + ONE;
    assign sigOut = sig_q;
    assign busy   = busy_q;
    assign done   = done_q;
    // Outputs are registered alongside the state, so they describe the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            gap_q   <= '0;
            sent_q  <= '0;
            gcnt_q  <= '0;
            sig_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (!enable) begin
            state_q <= IDLE;
            sig_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    sig_q  <= 1'b0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (start) begin
                        len_q  <= burstLen;
                        gap_q  <= gapLen;
                        sent_q <= '0;
                        busy_q <= 1'b1;
                        if (burstLen == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= PULSE;
                            sig_q   <= 1'b1;
                        end
                    end
                end
                PULSE: begin
                    sent_q <= sent_d;
                    if (sent_d == len_q) begin
                        state_q <= DONE;
                        sig_q   <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (gap_q == '0) begin
                        sig_q <= 1'b1;
                    end else begin
                        state_q <= GAP;
                        sig_q   <= 1'b0;
                        gcnt_q  <= gap_q;
                    end
                end
                GAP: begin
                    if (gcnt_q == ONE) begin
                        state_q <= PULSE;
                        sig_q   <= 1'b1;
                    end
                    gcnt_q <= gcnt_q - ONE;
                end
                DONE: begin
                    state_q <= IDLE;
                    sig_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    sig_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule
